// File: rtl/rsa_stream_adapter.sv
// Wide host bus <-> 32-bit RSA core bridge: operand collection, word serialisation, result capture/return.
// Optional key/mod caching across jobs is enabled by defining RSA_IF_KEY_CACHE_EN.
module rsa_stream_adapter #(
  parameter int BUS_W  = 512,
  parameter int WORD_W = 32,
  parameter int OPER_W = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BUS_W-1:0]  lcl_dout,
  input  logic              lcl_dv,
  input  logic              lcl_km_keep,
  output logic [BUS_W-1:0]  lcl_din,
  output logic              lcl_den,
  input  logic              lcl_idone,
  output logic [WORD_W-1:0] core_wr_data,
  output logic              core_wr_vld,
  output logic              core_key_rdy,
  output logic              core_mod_rdy,
  output logic              core_dat_rdy,
  input  logic              core_key_end,
  input  logic              core_mod_end,
  input  logic [WORD_W-1:0] core_dout,
  input  logic              core_dout_rdy,
  output logic              busy,
  output logic              rx_drop
);
  localparam int BEATS = OPER_W / BUS_W;
  localparam int WORDS = OPER_W / WORD_W;
  localparam int CW    = $clog2(WORDS + 1);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [3:0] {
    IDLE, RX, KEY_LD, KEY_WT, MOD_LD, MOD_WT, DAT_LD, RES_WT, RES_CAP, TX
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [1:0]        seg_q, seg_d;
  logic              keep_q, keep_d;
  logic              end_q, end_d;
  logic              rx_drop_q, rx_drop_d;
  logic [OPER_W-1:0] key_q, key_d, mod_q, mod_d, dat_q, dat_d;
  logic              cache_vld_q, cache_vld_d;

  logic              keep_eff, rx_take, ld_done, cap_last, job_last;
  logic [1:0]        wr_seg;
  logic [BW-1:0]     wr_beat;
  logic [CW-1:0]     widx;
  logic [OPER_W-1:0] ld_buf;

`ifdef RSA_IF_KEY_CACHE_EN
  assign keep_eff    = lcl_km_keep & cache_vld_q;
  assign cache_vld_d = cache_vld_q | ((state_q == DAT_LD) & ~keep_q);
`else
  logic unused_km_keep;
  assign unused_km_keep = lcl_km_keep;
  assign keep_eff       = 1'b0;
  assign cache_vld_d    = 1'b0;
`endif

  assign rx_take  = lcl_dv && (state_q == IDLE || state_q == RX);
  assign ld_done  = (cnt_q == CW'(WORDS));
  assign cap_last = (cnt_q == CW'(WORDS - 1));

  // The first beat of a job chooses its segment: data-only jobs skip key/mod.
  always_comb begin
    wr_seg  = seg_q;
    wr_beat = beat_q;
    if (state_q == IDLE) begin
      wr_seg  = keep_eff ? 2'd2 : 2'd0;
      wr_beat = '0;
    end
    job_last = (wr_beat == BW'(BEATS - 1)) && (wr_seg == 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_take) state_d = job_last ? DAT_LD : RX;
      RX:      if (rx_take && job_last) state_d = keep_q ? DAT_LD : KEY_LD;
      KEY_LD:  if (ld_done) state_d = (end_q || core_key_end) ? MOD_LD : KEY_WT;
      KEY_WT:  if (core_key_end) state_d = MOD_LD;
      MOD_LD:  if (ld_done) state_d = (end_q || core_mod_end) ? DAT_LD : MOD_WT;
      MOD_WT:  if (core_mod_end) state_d = DAT_LD;
      DAT_LD:  if (ld_done) state_d = RES_WT;
      RES_WT:  if (core_dout_rdy) state_d = RES_CAP;
      RES_CAP: if (cap_last) state_d = TX;
      TX:      if (lcl_idone && beat_q == BW'(BEATS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = '0;
    beat_d    = beat_q;
    seg_d     = seg_q;
    keep_d    = keep_q;
    end_d     = 1'b0;
    rx_drop_d = rx_drop_q | (lcl_dv & ~(state_q == IDLE || state_q == RX));
    key_d     = key_q;
    mod_d     = mod_q;
    dat_d     = dat_q;
    case (state_q)
      KEY_LD, MOD_LD, DAT_LD: cnt_d = ld_done ? '0 : cnt_q + CW'(1);
      RES_CAP: begin
        cnt_d = cap_last ? '0 : cnt_q + CW'(1);
        dat_d[int'(cnt_q) * WORD_W +: WORD_W] = core_dout;
      end
      TX: if (lcl_idone) beat_d = (beat_q == BW'(BEATS - 1)) ? '0 : beat_q + BW'(1);
      default: ;
    endcase
    // An end pulse seen mid-stream is held until the stream completes.
    if (state_q == KEY_LD && !ld_done) end_d = end_q | core_key_end;
    if (state_q == MOD_LD && !ld_done) end_d = end_q | core_mod_end;
    if (rx_take) begin
      if (state_q == IDLE) keep_d = keep_eff;
      case (wr_seg)
        2'd0:    key_d[int'(wr_beat) * BUS_W +: BUS_W] = lcl_dout;
        2'd1:    mod_d[int'(wr_beat) * BUS_W +: BUS_W] = lcl_dout;
        default: dat_d[int'(wr_beat) * BUS_W +: BUS_W] = lcl_dout;
      endcase
      if (wr_beat == BW'(BEATS - 1)) begin
        beat_d = '0;
        seg_d  = job_last ? 2'd0 : wr_seg + 2'd1;
      end else begin
        beat_d = wr_beat + BW'(1);
        seg_d  = wr_seg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      beat_q      <= '0;
      seg_q       <= '0;
      keep_q      <= 1'b0;
      end_q       <= 1'b0;
      rx_drop_q   <= 1'b0;
      cache_vld_q <= 1'b0;
      key_q       <= '0;
      mod_q       <= '0;
      dat_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      seg_q       <= seg_d;
      keep_q      <= keep_d;
      end_q       <= end_d;
      rx_drop_q   <= rx_drop_d;
      cache_vld_q <= cache_vld_d;
      key_q       <= key_d;
      mod_q       <= mod_d;
      dat_q       <= dat_d;
    end
  end

  always_comb begin
    busy         = (state_q != IDLE);
    rx_drop      = rx_drop_q;
    lcl_den      = (state_q == TX);
    lcl_din      = lcl_den ? dat_q[int'(beat_q) * BUS_W +: BUS_W] : '0;
    core_key_rdy = (state_q == KEY_LD) && (cnt_q == '0);
    core_mod_rdy = (state_q == MOD_LD) && (cnt_q == '0);
    core_dat_rdy = (state_q == DAT_LD) && (cnt_q == '0);
    core_wr_vld  = (state_q == KEY_LD || state_q == MOD_LD || state_q == DAT_LD) && (cnt_q != '0);
    widx         = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
    case (state_q)
      KEY_LD:  ld_buf = key_q;
      MOD_LD:  ld_buf = mod_q;
      default: ld_buf = dat_q;
    endcase
    core_wr_data = core_wr_vld ? ld_buf[int'(widx) * WORD_W +: WORD_W] : '0;
  end
endmodule

// File: tb/tb_rsa_stream_adapter.sv
// Self-checking bench for rsa_stream_adapter: operand words and result beats are scoreboarded in queues.
module tb_rsa_stream_adapter;
  localparam int BUS_W  = 512;
  localparam int WORD_W = 32;
  localparam int OPER_W = 1024;
  localparam int BEATS  = OPER_W / BUS_W;
  localparam int WORDS  = OPER_W / WORD_W;
  localparam int WPB    = BUS_W / WORD_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [BUS_W-1:0]  lcl_dout;
  logic              lcl_dv, lcl_km_keep, lcl_idone;
  logic [BUS_W-1:0]  lcl_din;
  logic              lcl_den;
  logic [WORD_W-1:0] core_wr_data, core_dout;
  logic              core_wr_vld, core_key_rdy, core_mod_rdy, core_dat_rdy;
  logic              core_key_end, core_mod_end, core_dout_rdy;
  logic              busy, rx_drop;

  int checks = 0;
  int failures = 0;
  logic [WORD_W-1:0] word_q[$];
  logic [BUS_W-1:0]  res_q[$];
  logic [BUS_W-1:0]  job_beats[3*BEATS];

  rsa_stream_adapter #(.BUS_W(BUS_W), .WORD_W(WORD_W), .OPER_W(OPER_W)) dut (
    .clk(clk), .rst_n(rst_n), .lcl_dout(lcl_dout), .lcl_dv(lcl_dv), .lcl_km_keep(lcl_km_keep),
    .lcl_din(lcl_din), .lcl_den(lcl_den), .lcl_idone(lcl_idone),
    .core_wr_data(core_wr_data), .core_wr_vld(core_wr_vld),
    .core_key_rdy(core_key_rdy), .core_mod_rdy(core_mod_rdy), .core_dat_rdy(core_dat_rdy),
    .core_key_end(core_key_end), .core_mod_end(core_mod_end),
    .core_dout(core_dout), .core_dout_rdy(core_dout_rdy), .busy(busy), .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy_of(input int sel);
    return (sel == 0) ? core_key_rdy : (sel == 1) ? core_mod_rdy : core_dat_rdy;
  endfunction

  function automatic logic [BUS_W-1:0] rand_beat();
    logic [BUS_W-1:0] b;
    for (int k = 0; k < WPB; k++) b[k*WORD_W +: WORD_W] = $urandom;
    return b;
  endfunction

  task automatic fill_random;
    for (int i = 0; i < 3*BEATS; i++) job_beats[i] = rand_beat();
  endtask

  task automatic send_beats(input int start, input int n, input bit keep);
    for (int i = start; i < start + n; i++) begin
      lcl_dv      = 1'b1;
      lcl_km_keep = keep && (i == start);
      lcl_dout    = job_beats[i];
      for (int w = 0; w < WPB; w++) word_q.push_back(job_beats[i][w*WORD_W +: WORD_W]);
      tick;
    end
    lcl_dv      = 1'b0;
    lcl_km_keep = 1'b0;
    lcl_dout    = '0;
  endtask

  task automatic load_phase(input int sel, input int end_at, input bit give_end);
    int n = 0;
    logic [WORD_W-1:0] exp;
    while (!rdy_of(sel) && n < 60) begin tick; n++; end
    checks++;
    if (rdy_of(sel) !== 1'b1) begin
      failures++;
      $display("FAIL load_rdy[%0d]: got=%b want=1 within 60 cycles", sel, rdy_of(sel));
    end
    for (int w = 0; w < WORDS; w++) begin
      tick;
      core_key_end = 1'b0;
      exp = (word_q.size() > 0) ? word_q.pop_front() : 'x;
      checks++;
      if ({core_wr_vld, core_wr_data} !== {1'b1, exp}) begin
        failures++;
        $display("FAIL load_word[%0d][%0d]: got vld=%b data=%h want vld=1 data=%h",
                 sel, w, core_wr_vld, core_wr_data, exp);
      end
      if (sel == 0 && w == end_at) core_key_end = 1'b1;
    end
    core_key_end = 1'b0;
    if (sel == 2 || !give_end) return;
    if (end_at >= 0) begin
      tick;
      checks++;
      if (core_mod_rdy !== 1'b1) begin
        failures++;
        $display("FAIL early_end_mod_ld: got core_mod_rdy=%b want=1", core_mod_rdy);
      end
    end else begin
      repeat (3) tick;
      checks++;
      if ({busy, core_wr_vld, core_wr_data} !== {1'b1, 1'b0, {WORD_W{1'b0}}}) begin
        failures++;
        $display("FAIL wait_idle_bus[%0d]: got busy=%b vld=%b data=%h want 1/0/0",
                 sel, busy, core_wr_vld, core_wr_data);
      end
      if (sel == 0) core_key_end = 1'b1; else core_mod_end = 1'b1;
      tick;
      core_key_end = 1'b0;
      core_mod_end = 1'b0;
    end
  endtask

  task automatic result_phase(input bit fixed, input int bp, input bit drop);
    logic [BUS_W-1:0] eb, held, exp;
    logic [WORD_W-1:0] rw;
    tick;
    tick;
    core_dout_rdy = 1'b1;
    tick;
    core_dout_rdy = 1'b0;
    for (int w = 0; w < WORDS; w++) begin
      rw = fixed ? 32'hA000_0000 + WORD_W'(w) : $urandom;
      core_dout = rw;
      eb[(w % WPB)*WORD_W +: WORD_W] = rw;
      if (w % WPB == WPB - 1) res_q.push_back(eb);
      tick;
    end
    core_dout = '0;
    checks++;
    if (lcl_den !== 1'b1) begin
      failures++;
      $display("FAIL den_rise: got lcl_den=%b want=1", lcl_den);
    end
    for (int b = 0; b < BEATS; b++) begin
      if (b == 0 && bp > 0) begin
        held = lcl_din;
        repeat (bp) begin
          tick;
          checks++;
          if ({lcl_den, lcl_din} !== {1'b1, held}) begin
            failures++;
            $display("FAIL backpressure_hold: got den=%b din=%h want den=1 din=%h", lcl_den, lcl_din, held);
          end
        end
      end
      if (b == 0 && drop) begin
        lcl_dv   = 1'b1;
        lcl_dout = '1;
        tick;
        lcl_dv   = 1'b0;
        lcl_dout = '0;
        checks++;
        if (rx_drop !== 1'b1) begin
          failures++;
          $display("FAIL rx_drop_set: got=%b want=1", rx_drop);
        end
      end
      exp = (res_q.size() > 0) ? res_q.pop_front() : 'x;
      checks++;
      if ({lcl_den, lcl_din} !== {1'b1, exp}) begin
        failures++;
        $display("FAIL result_beat[%0d]: got den=%b din=%h want den=1 din=%h", b, lcl_den, lcl_din, exp);
      end
      lcl_idone = 1'b1;
      tick;
      lcl_idone = 1'b0;
    end
    checks++;
    if ({lcl_den, busy} !== 2'b00) begin
      failures++;
      $display("FAIL tx_done: got den=%b busy=%b want 0/0", lcl_den, busy);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({lcl_den, lcl_din, core_wr_vld, core_wr_data, core_key_rdy, core_mod_rdy, core_dat_rdy,
         busy, rx_drop} !== '0) begin
      failures++;
      $display("FAIL %s: got den=%b din=%h vld=%b data=%h rdy=%b%b%b busy=%b drop=%b want all 0",
               tag, lcl_den, lcl_din, core_wr_vld, core_wr_data, core_key_rdy, core_mod_rdy,
               core_dat_rdy, busy, rx_drop);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    lcl_dout = '0; lcl_dv = 1'b0; lcl_km_keep = 1'b0; lcl_idone = 1'b0;
    core_key_end = 1'b0; core_mod_end = 1'b0; core_dout = '0; core_dout_rdy = 1'b0;
    repeat (3) tick;
    check_all_zero("reset_state");
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_full_job;
    for (int i = 0; i < 3*BEATS; i++) job_beats[i] = BUS_W'(i + 1);
    send_beats(0, 3*BEATS, 1'b0);
    load_phase(0, -1, 1'b1);
    load_phase(1, -1, 1'b1);
    load_phase(2, -1, 1'b1);
    result_phase(1'b1, 0, 1'b0);
  endtask

  task automatic test_back_pressure;
    fill_random();
    send_beats(0, 3*BEATS, 1'b0);
    load_phase(0, -1, 1'b1);
    load_phase(1, -1, 1'b1);
    load_phase(2, -1, 1'b1);
    result_phase(1'b0, 5, 1'b0);
  endtask

  task automatic test_early_key_end;
    fill_random();
    send_beats(0, 3*BEATS, 1'b0);
    load_phase(0, 10, 1'b1);
    load_phase(1, -1, 1'b1);
    load_phase(2, -1, 1'b1);
    result_phase(1'b0, 0, 1'b0);
  endtask

  task automatic test_cache;
    fill_random();
`ifdef RSA_IF_KEY_CACHE_EN
    send_beats(2*BEATS, BEATS, 1'b1);
    checks++;
    if ({core_key_rdy, core_mod_rdy, core_dat_rdy} !== 3'b001) begin
      failures++;
      $display("FAIL cache_dat_only: got rdy key/mod/dat=%b%b%b want 001",
               core_key_rdy, core_mod_rdy, core_dat_rdy);
    end
    load_phase(2, -1, 1'b1);
`else
    send_beats(0, BEATS, 1'b1);
    repeat (5) tick;
    checks++;
    if ({busy, core_key_rdy, core_dat_rdy} !== 3'b100) begin
      failures++;
      $display("FAIL nocache_waits: got busy=%b key_rdy=%b dat_rdy=%b want 1/0/0",
               busy, core_key_rdy, core_dat_rdy);
    end
    send_beats(BEATS, 2*BEATS, 1'b0);
    load_phase(0, -1, 1'b1);
    load_phase(1, -1, 1'b1);
    load_phase(2, -1, 1'b1);
`endif
    result_phase(1'b0, 0, 1'b0);
  endtask

  task automatic test_rx_drop;
    fill_random();
    send_beats(0, 3*BEATS, 1'b0);
    load_phase(0, -1, 1'b1);
    load_phase(1, -1, 1'b1);
    load_phase(2, -1, 1'b1);
    result_phase(1'b0, 2, 1'b1);
  endtask

  task automatic test_reset_mid_job;
    fill_random();
    send_beats(0, 3*BEATS, 1'b0);
    load_phase(0, -1, 1'b1);
    load_phase(1, -1, 1'b0);
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_in_mod_wt");
    word_q.delete();
    res_q.delete();
    tick;
    rst_n = 1'b1;
    tick;
    fill_random();
    send_beats(0, 3*BEATS, 1'b0);
    load_phase(0, -1, 1'b1);
    load_phase(1, -1, 1'b1);
    load_phase(2, -1, 1'b1);
    result_phase(1'b0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_back_pressure();
    test_early_key_end();
    test_cache();
    test_rx_drop();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
